// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and default constants for the oversampled UART receiver.
//   - rx_state_e     : receiver frame-tracking states
//   - DEF_OVERSAMPLE : default ticks per bit period
//   - DEF_DATA_BITS  : default data bits per frame
// ----------------------------------------------------------------------------
package uart_pkg;

  // IDLE      : waiting for a falling edge on the synchronised line
  // START     : qualifying the start bit at its midpoint
  // DATA      : sampling data bits at the middle of each bit period
  // STOP      : sampling the stop bit
  // WAIT_IDLE : after a framing error, hold off until the line returns high
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_os_if.sv
// ----------------------------------------------------------------------------
// uart_rx_os_if
//   Byte-output side of the UART receiver: a valid/ready holding register
//   plus the two error pulses.
//   - rx_data   : received byte, stable while rx_valid=1
//   - rx_valid  : holding register occupied
//   - rx_ready  : consumer accepts the byte on a clk edge with rx_valid=1
//   - frame_err : one-clk pulse, stop bit sampled low
//   - overrun   : one-clk pulse, completed byte dropped (register full)
//   Modports: master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface uart_rx_os_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/rx_sync.sv
// ----------------------------------------------------------------------------
// rx_sync
//   STAGES-deep flop chain bringing an asynchronous input into clk.
//   The chain resets to 1 so an idle-high serial line looks idle from the
//   first clk after reset and cannot fake a start bit.
//   Ports:
//   - clk   : system clock
//   - reset : synchronous, active-high
//   - d     : asynchronous input
//   - q     : synchronised output (d delayed by STAGES clk)
// ----------------------------------------------------------------------------
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// ----------------------------------------------------------------------------
// uart_rx_os
//   8N1-style UART receiver driven by an OVERSAMPLE x baud tick.
//   The line is synchronised, the start bit is qualified at its midpoint,
//   and every following bit is sampled one bit period later, i.e. near its
//   centre. Good bytes land in a valid/ready holding register; a low stop
//   bit raises frame_err, a byte arriving while the register is still full
//   and not being drained raises overrun.
//   Ports:
//   - clk   : system clock
//   - reset : synchronous, active-high; discards any partial frame
//   - tick  : one-clk enable at OVERSAMPLE x baud
//   - rxd   : asynchronous serial input, idle high
//   - rx_if : master side of uart_rx_os_if (byte handshake and pulses)
//   OVERSAMPLE must be even and >= 4; DATA_BITS must be >= 2.
// ----------------------------------------------------------------------------
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          rxd,
  uart_rx_os_if.master  rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Sample points: half a bit into the start bit, then whole bit periods.
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   good_frame;

  rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  // --------------------------------------------------------------------------
  // Frame FSM: advances only on tick.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    ferr_d     = 1'b0;
    good_frame = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            if (!rxd_s) begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              // Line went back high before mid-bit: treat as noise.
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            // LSB arrives first, so shift in from the top.
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              good_frame = 1'b1;
              state_d    = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        WAIT_IDLE: begin
          // A held-low break must not be re-read as a stream of start bits.
          if (rxd_s) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Holding register: handshake runs every clk, independent of tick.
  // --------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;

    if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
    end

    if (good_frame) begin
      // A byte being drained this very clk frees the slot for the new one.
      if (!valid_q || rx_if.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_os
//   Drives serial frames into uart_rx_os and checks the received bytes and
//   error pulses against a frame-level reference model. Expected bytes go
//   into a queue when a frame is sent; a monitor pops them when the DUT
//   hands a byte over.
// ----------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int CLKS_PER_TICK = 4;
  localparam int OS            = 16;
  localparam int BIT_CLKS      = CLKS_PER_TICK * OS;

  logic clk;
  logic reset;
  logic tick;
  logic rxd;

  uart_rx_os_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_os #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .rxd   (rxd),
    .rx_if (rx_if)
  );

  int tests;
  int failed;
  int cyc;
  int obs_ferr;
  int obs_ovr;
  int exp_ferr;
  int exp_ovr;
  int valid_cycles;
  int rise_cyc;
  int last_s;
  logic prev_valid;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick generator: tick is seen by the DUT on every edge whose index is a
  // multiple of CLKS_PER_TICK.
  initial begin
    cyc  = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1 tick = ((cyc + 1) % CLKS_PER_TICK) == 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: counts pulses and consumes bytes on each accepted handshake.
  initial begin
    logic [7:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rx_if.frame_err) obs_ferr++;
        if (rx_if.overrun)   obs_ovr++;
        if (rx_if.rx_valid) begin
          valid_cycles++;
          if (!prev_valid) rise_cyc = cyc;
        end
        prev_valid = rx_if.rx_valid;
        if (rx_if.rx_valid && rx_if.rx_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'h0, rx_if.rx_data}, 32'h100);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] byte accepted: got 0x%02h, model 0x%02h", rx_if.rx_data, e);
            check("rx_byte", {24'h0, rx_if.rx_data}, {24'h0, e});
          end
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // Sends one complete frame. The model predicts the edge on which the
  // receiver samples the stop bit: the start edge is seen after two sync
  // flops, qualified on the first tick after that, and the stop bit is
  // 9.5 bit periods (152 ticks) later. At that edge the frame outcome is
  // decided from the handshake rules. With pulse_ready, rx_ready is high
  // for exactly that edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input bit pulse_ready);
    logic [9:0] bits;
    int e0, t0, s;
    bits = {stop_val, b, 1'b0};
    e0 = cyc;
    t0 = ((e0 + 3 + CLKS_PER_TICK - 1) / CLKS_PER_TICK) * CLKS_PER_TICK;
    s  = t0 + (OS / 2 + 9 * OS) * CLKS_PER_TICK;
    last_s = s;
    $display("[TB] frame 0x%02h stop=%0b pulse_ready=%0b", b, stop_val, pulse_ready);
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      for (int k = 0; k < BIT_CLKS; k++) begin
        step(1);
        if (cyc == s) begin
          if (!stop_val) exp_ferr++;
          else if (exp_q.size() == 0 || rx_if.rx_ready) exp_q.push_back(b);
          else exp_ovr++;
          if (pulse_ready) rx_if.rx_ready = 1'b0;
        end
        if (pulse_ready && cyc == s - 1) rx_if.rx_ready = 1'b1;
      end
    end
  endtask

  // Start bit plus the first nbits data bits, then stop driving the frame.
  task automatic send_partial(input logic [7:0] b, input int nbits);
    $display("[TB] partial frame 0x%02h, %0d data bits", b, nbits);
    rxd = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      rxd = b[i];
      step(BIT_CLKS);
    end
  endtask

  initial begin
    int f0;
    int o0;
    logic [7:0] rb;
    logic stop_bit;
    tests = 0; failed = 0;
    obs_ferr = 0; obs_ovr = 0; exp_ferr = 0; exp_ovr = 0;
    valid_cycles = 0; rise_cyc = 0; last_s = 0;
    reset = 1'b1;
    rxd = 1'b1;
    rx_if.rx_ready = 1'b1;
    step(3);
    check("reset_rx_valid", {31'h0, rx_if.rx_valid}, 0);
    check("reset_rx_data", {24'h0, rx_if.rx_data}, 0);
    check("reset_frame_err", {31'h0, rx_if.frame_err}, 0);
    check("reset_overrun", {31'h0, rx_if.overrun}, 0);
    reset = 1'b0;
    step(20);

    // Basic frame, latency and single-cycle valid.
    valid_cycles = 0;
    f0 = obs_ferr;
    send_frame(8'hA5, 1'b1, 1'b0);
    step(8);
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_latency_edge", rise_cyc, last_s);
    check("a5_no_frame_err", obs_ferr - f0, 0);

    // Short low glitch must abort at the mid-start sample.
    valid_cycles = 0;
    f0 = obs_ferr;
    $display("[TB] glitch 20 clk");
    rxd = 1'b0;
    step(20);
    rxd = 1'b1;
    step(3 * BIT_CLKS);
    check("glitch_no_valid", valid_cycles, 0);
    check("glitch_no_frame_err", obs_ferr - f0, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    step(8);

    // Framing error followed by a held-low break: exactly one pulse.
    valid_cycles = 0;
    f0 = obs_ferr;
    send_frame(8'h81, 1'b0, 1'b0);
    step(200);
    rxd = 1'b1;
    step(2 * BIT_CLKS);
    check("break_one_frame_err", obs_ferr - f0, 1);
    check("break_no_valid", valid_cycles, 0);
    send_frame(8'h42, 1'b1, 1'b0);
    step(8);

    // Overrun: second byte dropped while the first is held.
    rx_if.rx_ready = 1'b0;
    o0 = obs_ovr;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    step(8);
    check("ovr_data_held", {24'h0, rx_if.rx_data}, 32'h11);
    check("ovr_valid_held", {31'h0, rx_if.rx_valid}, 1);
    check("ovr_one_pulse", obs_ovr - o0, 1);
    rx_if.rx_ready = 1'b1;
    step(2);
    check("ovr_valid_cleared", {31'h0, rx_if.rx_valid}, 0);

    // Drain and reload in the same clk: no overrun.
    rx_if.rx_ready = 1'b0;
    o0 = obs_ovr;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    step(4);
    check("swap_data", {24'h0, rx_if.rx_data}, 32'h55);
    check("swap_valid", {31'h0, rx_if.rx_valid}, 1);
    check("swap_no_overrun", obs_ovr - o0, 0);
    rx_if.rx_ready = 1'b1;
    step(2);
    check("swap_valid_cleared", {31'h0, rx_if.rx_valid}, 0);

    // Reset mid-frame with a byte also held.
    rx_if.rx_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    send_partial(8'hF0, 4);
    reset = 1'b1;
    step(1);
    check("midreset_rx_valid", {31'h0, rx_if.rx_valid}, 0);
    check("midreset_rx_data", {24'h0, rx_if.rx_data}, 0);
    check("midreset_frame_err", {31'h0, rx_if.frame_err}, 0);
    check("midreset_overrun", {31'h0, rx_if.overrun}, 0);
    exp_q.delete();
    reset = 1'b0;
    rxd = 1'b1;
    step(2 * BIT_CLKS);
    rx_if.rx_ready = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b0);
    step(8);

    // Randomised frames with occasional bad stop bits and idle gaps.
    for (int n = 0; n < 20; n++) begin
      rb = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 4) != 0);
      send_frame(rb, stop_bit, 1'b0);
      if (!stop_bit) begin
        step($urandom_range(0, 100));
        rxd = 1'b1;
        step(BIT_CLKS);
      end
      step($urandom_range(1, 100));
    end
    step(16);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_frame_err_count", obs_ferr, exp_ferr);
    check("final_overrun_count", obs_ovr, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 8N1 UART receiver. It consumes a 16x-oversample tick from the baud generator and deserialises the `rxd` line into bytes.
- Bytes are presented on a valid/ready holding register, with framing-error and overrun indications.
- Sits between the baud-rate generator and the downstream byte consumer (command parser/FIFO).

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 4.
- SYNC_STAGES, 2, flops in the `rxd` metastability synchroniser.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate.
- rxd  in  1  asynchronous serial input, idle high.
- rx_data  out  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available in the holding register.
- rx_ready  in  1  consumer accepts the byte when rx_valid and rx_ready are both 1 on a clk edge.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- overrun  out  1  one-clk pulse when a completed byte is dropped because the holding register is still full.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Synchroniser flops reset to 1.
  - State=IDLE; sample count=0; bit count=0.
- Reset takes priority over everything, including mid-frame; the partial frame is discarded.
- All FSM activity advances only on clk edges where tick=1, except the handshake and pulse outputs, which operate every clk.
- rxd_s is rxd after SYNC_STAGES flops.
- States:
  - IDLE: on a tick with rxd_s=0, go to START and clear the sample count.
  - START: count ticks. At count=OVERSAMPLE/2-1 (mid start bit), sample rxd_s:
    - rxd_s=0: go to DATA, clear the sample count and bit count.
    - rxd_s=1: false start, return to IDLE with no outputs.
  - DATA:
    - Count ticks. At count=OVERSAMPLE-1, shift rxd_s into the shift register MSB (LSB-first reception), wrap the count to 0, and increment the bit count.
    - After bit DATA_BITS-1 is sampled, go to STOP.
  - STOP: at count=OVERSAMPLE-1, sample rxd_s:
    - rxd_s=1 (good frame): load the holding register per the handshake rules; go to IDLE.
    - rxd_s=0 (framing error): pulse frame_err on the next clk, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: on a tick with rxd_s=1, go to IDLE. This makes a held-low break produce exactly one frame_err.
- Handshake and holding register:
  - On a good frame with rx_valid=0: rx_data<=shift register and rx_valid<=1 on the next clk.
  - On a good frame with rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data is unchanged, and overrun pulses on the next clk.
  - On a good frame with rx_valid=1 and rx_ready=1 in the same clk: the old byte is consumed, the new byte is loaded, rx_valid stays 1, and there is no overrun.
  - Otherwise, rx_valid clears on the clk after a rx_valid and rx_ready handshake.
- Latency: rx_valid rises 1 clk after the tick that samples the stop bit. Nominally this is 9.5 bit periods after the start edge, plus sync delay.
- Widths:
  - Sample count is clog2(OVERSAMPLE) bits.
  - Bit count is clog2(DATA_BITS+1) bits.
  - No counter is allowed to wrap past its terminal value.
- frame_err and overrun never assert in the same clk.

Decomposition:
- Package uart_pkg holds:
  - The state enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - Default constants: OVERSAMPLE=16, DATA_BITS=8.
- Sub-module rx_sync: SYNC_STAGES-deep synchroniser with reset value 1, instantiated on rxd.
- All other logic stays in one module.

Test Plan (tick every 4 clk; one bit = 64 clk; rx_ready=1 unless stated):
- Frame 0xA5 (start 0, data bits LSB first 1,0,1,0,0,1,0,1, stop 1) -> rx_data=0xA5, rx_valid=1 for exactly 1 clk, frame_err=0.
- Low glitch of 20 clk on idle line -> START aborts at mid-bit sample; no rx_valid, no frame_err; next frame 0x3C received correctly.
- Frame 0x81 with stop bit driven 0, then line held low 200 clk, then high -> one frame_err pulse, no rx_valid; next frame 0x42 received.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse at the end of 0x22; raising rx_ready clears rx_valid.
- rx_ready pulsed in the exact clk the 0x55 stop bit completes while 0x11 is held -> rx_data becomes 0x55, rx_valid stays 1, overrun=0.
- reset asserted mid-DATA of 0xF0 -> all outputs 0 next clk; the following full frame 0x0F is received correctly.
